// File: rtl/feature_threshold_fetch.sv
`timescale 1ns/1ps
// feature_threshold_fetch: fetches one signed threshold per feature request from a registered ROM
// and returns the signed compare result over a valid/ready handshake.
module feature_threshold_fetch #(
  parameter int W_DATA     = 12,
  parameter int W_ADDR     = 8,
  parameter int W_SUM      = 20,
  parameter int N_FEATURES = 136
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [W_ADDR-1:0] req_idx,
  input  logic [W_SUM-1:0]  req_sum,
  input  logic              req_last,
  output logic              rom_en,
  output logic [W_ADDR-1:0] rom_addr,
  input  logic [W_DATA-1:0] rom_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_pass,
  output logic              res_oor,
  output logic [W_SUM-1:0]  res_thr,
  output logic              res_last,
  output logic [W_ADDR-1:0] res_pos
);
  typedef enum logic [1:0] {IDLE, FETCH, CMP, OUT} state_t;
  state_t                  r_state, w_next;
  logic [W_ADDR-1:0]       r_addr, r_cnt, r_pos;
  logic [W_SUM-1:0]        r_sum, r_thr;
  logic                    r_last, r_pass, r_oor, r_res_last;
  logic                    w_accept, w_res_hs, w_oor;
  logic signed [W_SUM-1:0] w_thr;
  assign w_thr     = W_SUM'($signed(rom_data));
  assign w_oor     = int'(r_addr) >= N_FEATURES;
  assign req_ready = (r_state == IDLE) || (r_state == OUT && res_ready);
  assign w_accept  = req_valid && req_ready;
  assign w_res_hs  = res_valid && res_ready;
  assign rom_en    = r_state == FETCH;
  assign rom_addr  = r_addr;
  assign res_valid = r_state == OUT;
  assign res_pass  = r_pass;
  assign res_oor   = r_oor;
  assign res_thr   = r_thr;
  assign res_last  = r_res_last;
  assign res_pos   = r_pos;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = req_valid ? FETCH : IDLE;
      FETCH: w_next = CMP;
      CMP:   w_next = OUT;
      OUT:   w_next = res_ready ? (req_valid ? FETCH : IDLE) : OUT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_sum      <= '0;
      r_last     <= 1'b0;
      r_pass     <= 1'b0;
      r_oor      <= 1'b0;
      r_thr      <= '0;
      r_res_last <= 1'b0;
      r_pos      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= req_idx;
        r_sum  <= req_sum;
        r_last <= req_last;
      end
      // out-of-range entries read back as zero but must never pass
      if (r_state == CMP) begin
        r_pass     <= !w_oor && ($signed(r_sum) >= w_thr);
        r_oor      <= w_oor;
        r_thr      <= w_thr;
        r_res_last <= r_last;
        r_pos      <= r_cnt;
      end
      if (w_res_hs) r_cnt <= r_res_last ? '0 : r_cnt + 1'b1;
    end
  end
endmodule
